// File: rtl/pl_ctrl_axil_arbiter_pkg.sv
// Shared types and constants for the PL control-unit AXI4-Lite arbiter.
package pl_ctrl_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_WR_AW_W,
        S_WR_B,
        S_RD_AR,
        S_RD_R,
        S_RESP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [3:0] REG0 = 4'h0;
    localparam logic [3:0] REG1 = 4'h4;
    localparam logic [3:0] REG2 = 4'h8;
    localparam logic [3:0] REG3 = 4'hC;

endpackage

// File: rtl/pl_ctrl_axil_arbiter_if.sv
// AXI4-Lite bus between the arbiter (master) and the control-unit register slave.
interface pl_ctrl_axil_arbiter_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/pl_ctrl_axil_arbiter_rr.sv
// Round-robin pick: first set request at or above ptr_i, wrapping at NUM_REQ-1.
module pl_ctrl_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic               gnt_vld_o,
    output logic [PTR_W-1:0]   gnt_idx_o
);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [PTR_W:0]       sum;

    // rot[i] is the request i places after the pointer
    assign dbl = {req_i, req_i};
    assign rot = dbl[ptr_i +: NUM_REQ];

    always_comb begin
        sum = '0;
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            if (rot[i]) sum = (PTR_W+1)'(i);
        end
        sum = sum + {1'b0, ptr_i};
        if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
        gnt_vld_o = |req_i;
        gnt_idx_o = sum[PTR_W-1:0];
    end
endmodule

// File: rtl/pl_ctrl_axil_arbiter.sv
// Round-robin sharing of one AXI4-Lite register slave between NUM_REQ requesters.
// Optional watchdog: define PL_CTRL_ARB_TIMEOUT_EN to abort stalled transactions with SLVERR.
module pl_ctrl_axil_arbiter
    import pl_ctrl_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                             ACLK,
    input  logic                             ARESET,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic [1:0]                       rsp_resp,
    pl_ctrl_axil_arbiter_if.master           m_axi
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0]    ONE_HOT0  = NUM_REQ'(1);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_arr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_arr;
    assign addr_arr  = req_addr;
    assign wdata_arr = req_wdata;

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d, idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic                    awv_q, awv_d, wv_q, wv_d, bready_q, bready_d;
    logic                    arv_q, arv_d, rready_q, rready_d;
    logic [NUM_REQ-1:0]      req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
    logic                    gnt_vld;
    logic [PTR_W-1:0]        gnt_idx;

    // ptr_q holds the highest-priority requester, so requester 0 wins first after reset
    pl_ctrl_rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx)
    );

`ifdef PL_CTRL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        awv_d       = awv_q;
        wv_d        = wv_q;
        bready_d    = bready_q;
        arv_d       = arv_q;
        rready_d    = rready_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
`ifdef PL_CTRL_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: if (gnt_vld) begin
                idx_d   = gnt_idx;
                state_d = S_GRANT;
            end
            S_GRANT: begin
                state_d = S_IDLE;
                if (req_valid[idx_q]) begin
                    addr_d      = addr_arr[idx_q];
                    wdata_d     = wdata_arr[idx_q];
                    req_ready_d = ONE_HOT0 << idx_q;
                    ptr_d       = (idx_q == PTR_W'(NUM_REQ-1)) ? '0 : idx_q + PTR_W'(1);
`ifdef PL_CTRL_ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                    if (req_write[idx_q]) begin
                        awv_d   = 1'b1;
                        wv_d    = 1'b1;
                        state_d = S_WR_AW_W;
                    end else begin
                        arv_d   = 1'b1;
                        state_d = S_RD_AR;
                    end
                end
            end
            S_WR_AW_W: begin
                if (awv_q && m_axi.AWREADY) awv_d = 1'b0;
                if (wv_q && m_axi.WREADY)   wv_d  = 1'b0;
                if (!awv_d && !wv_d) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_B;
                end
            end
            S_WR_B: if (m_axi.BVALID) begin
                bready_d    = 1'b0;
                resp_d      = m_axi.BRESP;
                rdata_d     = '0;
                rsp_valid_d = ONE_HOT0 << idx_q;
                state_d     = S_RESP;
            end
            S_RD_AR: if (m_axi.ARREADY) begin
                arv_d    = 1'b0;
                rready_d = 1'b1;
                state_d  = S_RD_R;
            end
            S_RD_R: if (m_axi.RVALID) begin
                rready_d    = 1'b0;
                rdata_d     = m_axi.RDATA;
                resp_d      = m_axi.RRESP;
                rsp_valid_d = ONE_HOT0 << idx_q;
                state_d     = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef PL_CTRL_ARB_TIMEOUT_EN
        // a handshake completing in the expiry cycle still wins over the abort
        if (state_q inside {S_WR_AW_W, S_WR_B, S_RD_AR, S_RD_R}) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES-1) && state_d != S_RESP) begin
                awv_d       = 1'b0;
                wv_d        = 1'b0;
                bready_d    = 1'b0;
                arv_d       = 1'b0;
                rready_d    = 1'b0;
                resp_d      = RESP_SLVERR;
                rdata_d     = '0;
                rsp_valid_d = ONE_HOT0 << idx_q;
                state_d     = S_RESP;
            end
        end
`endif
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= RESP_OKAY;
            awv_q       <= 1'b0;
            wv_q        <= 1'b0;
            bready_q    <= 1'b0;
            arv_q       <= 1'b0;
            rready_q    <= 1'b0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
`ifdef PL_CTRL_ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            awv_q       <= awv_d;
            wv_q        <= wv_d;
            bready_q    <= bready_d;
            arv_q       <= arv_d;
            rready_q    <= rready_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
`ifdef PL_CTRL_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;
    assign m_axi.AWADDR  = addr_q & WORD_MASK;
    assign m_axi.ARADDR  = addr_q & WORD_MASK;
    assign m_axi.WDATA   = wdata_q;
    assign m_axi.AWVALID = awv_q;
    assign m_axi.WVALID  = wv_q;
    assign m_axi.BREADY  = bready_q;
    assign m_axi.ARVALID = arv_q;
    assign m_axi.RREADY  = rready_q;
endmodule

// File: tb/tb_pl_ctrl_axil_arbiter.sv
// Scoreboard bench: directed requests, a behavioural register slave, and a response monitor.
module tb_pl_ctrl_axil_arbiter;
    import pl_ctrl_arb_pkg::*;

    localparam int NR = 2, AW = 4, DW = 32, TMO = 16;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]         req_valid = '0, req_write = '0;
    logic [NR-1:0][AW-1:0] req_addr  = '0;
    logic [NR-1:0][DW-1:0] req_wdata = '0;
    logic [NR-1:0]         req_ready, rsp_valid;
    logic [DW-1:0]         rsp_rdata;
    logic [1:0]            rsp_resp;

    pl_ctrl_axil_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    pl_ctrl_axil_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .ACLK(clk), .ARESET(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi(axi)
    );

    int checks = 0, failures = 0;
    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct { int idx; logic [DW-1:0] rdata; logic [1:0] resp; } exp_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wexp_t;
    exp_t          sb_q[$];
    wexp_t         aw_q[$];
    logic [AW-1:0] ar_q[$];
    int            grant_log[$];

    // slave model state
    logic [DW-1:0] mem [4];
    int aw_dly = 0, w_dly = 0, ar_dly = 0, aw_cnt, w_cnt, ar_cnt;
    bit silent = 0, r_silent = 0, aw_done, w_done, ar_done, b_arm, r_arm;
    logic [1:0] bresp_v = RESP_OKAY;
    logic [AW-1:0] aw_a, ar_a;
    logic [DW-1:0] w_d;

    // monitor state
    int cyc = 0, rsp_cnt = 0, awv_cyc = 0, wv_cyc = 0, b_hs = 0, valid_cyc = 0, av_rise = 0, last_rsp = 0;
    bit av_prev = 0;
    exp_t  e;
    wexp_t we;

    task automatic slave_clr();
        axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 0; axi.BRESP = 0;
        axi.ARREADY = 0; axi.RVALID = 0; axi.RDATA = 0; axi.RRESP = 0;
        aw_done = 0; w_done = 0; ar_done = 0; b_arm = 0; r_arm = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        aw_q.delete(); ar_q.delete();
    endtask

    initial forever @(posedge clk) cyc++;

    initial forever begin
        @(negedge clk);
        if (!rst && !silent) begin
            if (axi.AWREADY) begin axi.AWREADY = 0; aw_done = 1; end
            else if (axi.AWVALID && !aw_done) begin
                if (aw_cnt >= aw_dly) begin axi.AWREADY = 1; aw_a = axi.AWADDR; end else aw_cnt++;
            end
            if (axi.WREADY) begin axi.WREADY = 0; w_done = 1; end
            else if (axi.WVALID && !w_done) begin
                if (w_cnt >= w_dly) begin axi.WREADY = 1; w_d = axi.WDATA; end else w_cnt++;
            end
            if (b_arm) begin
                axi.BVALID = 0; b_arm = 0; aw_done = 0; w_done = 0; aw_cnt = 0; w_cnt = 0;
            end else if (aw_done && w_done && !axi.BVALID) begin
                mem[aw_a[3:2]] = w_d;
                axi.BRESP = bresp_v; axi.BVALID = 1;
                chk("aw_expected", aw_q.size() > 0, 1);
                if (aw_q.size() > 0) begin
                    we = aw_q.pop_front();
                    chk("awaddr", aw_a, we.addr);
                    chk("wdata", w_d, we.data);
                end
            end
            if (axi.BVALID && axi.BREADY) b_arm = 1;
            if (axi.ARREADY) begin axi.ARREADY = 0; ar_done = 1; end
            else if (axi.ARVALID && !ar_done) begin
                if (ar_cnt >= ar_dly) begin
                    axi.ARREADY = 1; ar_a = axi.ARADDR;
                    chk("ar_expected", ar_q.size() > 0, 1);
                    if (ar_q.size() > 0) chk("araddr", ar_a, ar_q.pop_front());
                end else ar_cnt++;
            end
            if (r_arm) begin
                axi.RVALID = 0; r_arm = 0; ar_done = 0; ar_cnt = 0;
            end else if (ar_done && !axi.RVALID && !r_silent) begin
                axi.RDATA = mem[ar_a[3:2]]; axi.RRESP = RESP_OKAY; axi.RVALID = 1;
            end
            if (axi.RVALID && axi.RREADY) r_arm = 1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (axi.AWVALID) awv_cyc++;
        if (axi.WVALID) wv_cyc++;
        if (axi.BVALID && axi.BREADY) b_hs++;
        if (axi.AWVALID || axi.WVALID || axi.ARVALID) valid_cyc++;
        if ((axi.AWVALID || axi.ARVALID) && !av_prev) av_rise = cyc;
        av_prev = axi.AWVALID || axi.ARVALID;
        for (int i = 0; i < NR; i++) if (req_ready[i]) grant_log.push_back(i);
        if (|rsp_valid) begin
            rsp_cnt++;
            last_rsp = cyc;
            chk("rsp_expected", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("rsp_idx", rsp_valid, 64'(1) << e.idx);
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_resp", rsp_resp, e.resp);
            end
        end
    end

    task automatic expect_rsp(int k, logic [DW-1:0] rd, logic [1:0] rs);
        exp_t x;
        x.idx = k; x.rdata = rd; x.resp = rs;
        sb_q.push_back(x);
    endtask

    task automatic expect_aw(logic [AW-1:0] a, logic [DW-1:0] d);
        wexp_t x;
        x.addr = a; x.data = d;
        aw_q.push_back(x);
    endtask

    task automatic drive(int k, bit wr, logic [AW-1:0] a, logic [DW-1:0] d);
        bit got = 0;
        req_write[k] = wr; req_addr[k] = a; req_wdata[k] = d; req_valid[k] = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready[k]) begin got = 1; break; end
        end
        req_valid[k] = 0;
        chk("req_ready_seen", got, 1);
    endtask

    task automatic drain(string nm);
        int n = 0;
        while (sb_q.size() != 0 && n < 400) begin @(negedge clk); n++; end
        chk(nm, sb_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        slave_clr();
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    int t_issue, rsp_before;
    bit seen;
    int exp_order[4] = '{0, 1, 0, 1};

    initial begin
        slave_clr();
        for (int i = 0; i < 4; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {req_ready, rsp_valid, rsp_resp, axi.AWVALID, axi.WVALID,
                           axi.BREADY, axi.ARVALID, axi.RREADY}, 0);
        chk("reset_data", {rsp_rdata, axi.WDATA}, 0);
        chk("reset_addr", {axi.AWADDR, axi.ARADDR}, 0);
        rst = 0;
        valid_cyc = 0;
        repeat (100) @(negedge clk);
        chk("idle_no_valid", valid_cyc, 0);

        // basic write then read-back with latency
        expect_aw(REG1, 32'h2); expect_rsp(0, 32'h0, RESP_OKAY);
        t_issue = cyc;
        drive(0, 1, REG1, 32'h2);
        drain("drain_wr");
        chk("lat_awvalid", av_rise - t_issue, 2);
        chk("lat_rsp_wr", last_rsp - t_issue, 4);
        ar_q.push_back(REG1); expect_rsp(0, 32'h2, RESP_OKAY);
        t_issue = cyc;
        drive(0, 0, REG1, 32'h0);
        drain("drain_rd");
        chk("lat_arvalid", av_rise - t_issue, 2);
        chk("lat_rsp_rd", last_rsp - t_issue, 4);

        // unaligned address is word-aligned on the bus; BRESP passes through
        bresp_v = RESP_SLVERR;
        expect_aw(REG1, 32'h55); expect_rsp(1, 32'h0, RESP_SLVERR);
        drive(1, 1, 4'h6, 32'h55);
        drain("drain_slverr");
        bresp_v = RESP_OKAY;
        ar_q.push_back(REG1); expect_rsp(1, 32'h55, RESP_OKAY);
        drive(1, 0, 4'h7, 32'h0);
        drain("drain_rd_unaligned");

        // AWREADY late, WREADY immediate
        aw_dly = 3; awv_cyc = 0; wv_cyc = 0; b_hs = 0;
        expect_aw(REG3, 32'hDEADBEEF); expect_rsp(0, 32'h0, RESP_OKAY);
        drive(0, 1, REG3, 32'hDEADBEEF);
        drain("drain_aw_late");
        chk("awvalid_cycles", awv_cyc, 4);
        chk("wvalid_cycles", wv_cyc, 1);
        chk("b_handshakes", b_hs, 1);
        aw_dly = 0;

        // both requesters continuously valid after reset: 0,1,0,1
        do_reset();
        grant_log.delete();
        expect_aw(REG0, 32'hA0); expect_rsp(0, 32'h0, RESP_OKAY);
        expect_aw(REG2, 32'hB1); expect_rsp(1, 32'h0, RESP_OKAY);
        expect_aw(REG0, 32'hA2); expect_rsp(0, 32'h0, RESP_OKAY);
        expect_aw(REG2, 32'hB3); expect_rsp(1, 32'h0, RESP_OKAY);
        fork
            begin drive(0, 1, REG0, 32'hA0); drive(0, 1, REG0, 32'hA2); end
            begin drive(1, 1, REG2, 32'hB1); drive(1, 1, REG2, 32'hB3); end
        join
        drain("drain_rr");
        chk("grant_count", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("grant_order", grant_log[i], exp_order[i]);

`ifdef PL_CTRL_ARB_TIMEOUT_EN
        silent = 1;
        expect_rsp(0, 32'h0, RESP_SLVERR);
        drive(0, 1, REG2, 32'h7);
        drain("drain_timeout");
        chk("timeout_latency", last_rsp - av_rise, TMO);
        chk("timeout_valids_low", {axi.AWVALID, axi.WVALID, axi.BREADY}, 0);
        silent = 0;
        slave_clr();
`endif

        // reset while waiting in the read-data phase
        r_silent = 1;
        ar_q.push_back(REG0);
        drive(0, 0, REG0, 32'h0);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (axi.RREADY) begin seen = 1; break; end
            @(negedge clk);
        end
        chk("rd_r_reached", seen, 1);
        rsp_before = rsp_cnt;
        rst = 1;
        #1;
        chk("midreset_ctrl", {req_ready, rsp_valid, axi.AWVALID, axi.WVALID,
                              axi.BREADY, axi.ARVALID, axi.RREADY}, 0);
        slave_clr();
        r_silent = 0;
        @(negedge clk);
        rst = 0;
        repeat (20) @(negedge clk);
        chk("no_rsp_after_reset", rsp_cnt - rsp_before, 0);
        ar_q.push_back(REG1); expect_rsp(1, 32'h55, RESP_OKAY);
        drive(1, 0, REG1, 32'h0);
        drain("drain_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
